piso8_mux_ctrl: RTL
===================

PISO8_MUX_CTRL -- requirements
Module: piso8_mux_ctrl

Interface
REQ-001 Parameter: MSB_FIRST, 0, scan order; 0 = index 0..7 (a first), 1 = index 7..0 (h first).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 load_valid  in  1  parallel word offered.
REQ-005 din  in  8  parallel word; bit i goes to mux input i (a=bit0 ... h=bit7).
REQ-006 load_ready  out  1  block accepts a word.
REQ-007 a,b,c,d,e,f,g,h  out  1 each  registered mux data inputs, held for the whole frame.
REQ-008 s,s1,s2  out  1 each  registered mux selects; mux index = {s,s1,s2}, s = MSB.
REQ-009 y  in  1  8:1 mux output, combinational from a..h/s..s2.
REQ-010 ser_out  out  1  registered serial bit.
REQ-011 ser_valid  out  1  ser_out holds a valid bit.
REQ-012 ser_last  out  1  current ser_out is the frame's 8th bit.
REQ-013 out_ready  in  1  downstream accepts ser_out this cycle.
REQ-014 frame_done  out  1  one-cycle pulse when the last bit is accepted.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, SHIFT and DRAIN.
REQ-017 load_ready SHALL equal 1 only in IDLE; load_valid outside IDLE SHALL be ignored.
REQ-018 On load_valid&load_ready, din SHALL be captured into a..h, idx SHALL be set to 0 (MSB_FIRST=0) or 7 (MSB_FIRST=1), and the FSM SHALL enter SHIFT.
REQ-019 {s,s1,s2} SHALL always equal idx.
REQ-020 In SHIFT, a step SHALL occur when (!ser_valid || out_ready).
REQ-021 On a step: ser_out<=y, ser_valid<=1, ser_last<=(idx is the final index), and idx advances by +1 or -1 per MSB_FIRST.
REQ-022 Each bit SHALL appear on ser_out exactly one cycle after its select is presented, with no stall.
REQ-023 The step that captures the final index SHALL move the FSM to DRAIN, and idx SHALL NOT wrap.
REQ-024 In SHIFT and DRAIN, ser_valid&out_ready with no new step SHALL clear ser_valid.
REQ-025 In DRAIN, ser_valid&ser_last&out_ready SHALL pulse frame_done for one cycle, clear ser_valid and ser_last, and return the FSM to IDLE.
REQ-026 While out_ready=0 and ser_valid=1, ser_out, ser_last and idx SHALL hold.
REQ-027 With out_ready held at 1, a frame SHALL take 1 load cycle plus 8 serial cycles; the next load SHALL be accepted no earlier than the cycle after frame_done.
REQ-028 a..h SHALL NOT change between load and return to IDLE.

Reset
REQ-029 While rst=1: FSM=IDLE, idx=0, s=s1=s2=0, a..h=0, ser_out=0, ser_valid=0, ser_last=0, frame_done=0, busy=0, load_ready=0.
REQ-030 After rst deasserts, load_ready SHALL become 1 from the first clock edge.
REQ-031 Reset mid-frame SHALL abort the frame with no frame_done pulse and no residual ser_valid.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (2-bit), IDX_W=3, NUM_IN=8, and the first/last index constants.
REQ-033 The 8:1 mux SHALL stay external; the block SHALL contain no sub-module other than optionally scan_idx_ctr (3-bit up/down index counter with load and enable).

Verification
REQ-034 Bench SHALL instantiate this block together with mux8_1to4 (y fed back).
REQ-035 Scenario 1: rst pulse mid-clock -> all outputs 0 immediately; load_ready=1 after the next edge.
REQ-036 Scenario 2: MSB_FIRST=0, din=8'b1000_0001, out_ready=1 -> ser_out 1,0,0,0,0,0,0,1 on 8 consecutive cycles; ser_last on the 8th; frame_done the cycle after.
REQ-037 Scenario 3: MSB_FIRST=1, din=8'h0B -> ser_out 0,0,0,0,1,0,1,1; selects go 111 down to 000.
REQ-038 Scenario 4: din=8'h08, out_ready=0 for 3 cycles after the first bit -> ser_out and {s,s1,s2} hold; sequence resumes intact; index 3 (s=0,s1=1,s2=1) yields 1.
REQ-039 Scenario 5: load_valid held high with din changing during a frame -> a..h unchanged; second word accepted only after frame_done.
REQ-040 Scenario 6: rst asserted after 4 bits -> no frame_done; next frame din=8'hFF emits eight 1s.

Source files
------------

// File: rtl/piso8_mux_ctrl_pkg.sv
// Shared definitions for the 8-bit parallel-in/serial-out controller that scans an external 8:1 mux.
package piso8_mux_ctrl_pkg;
  localparam int IDX_W  = 3;
  localparam int NUM_IN = 8;
  localparam logic [IDX_W-1:0] IDX_LO = 3'd0;
  localparam logic [IDX_W-1:0] IDX_HI = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic [IDX_W-1:0] first_idx(input logic msb_first);
    return msb_first ? IDX_HI : IDX_LO;
  endfunction

  function automatic logic [IDX_W-1:0] last_idx(input logic msb_first);
    return msb_first ? IDX_LO : IDX_HI;
  endfunction
endpackage

// File: rtl/mux8_1to4.sv
// External 8:1 mux companion (two 4:1 halves selected by s); {s,s1,s2} is the input index.
module mux8_1to4 (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic e,
  input  logic f,
  input  logic g,
  input  logic h,
  input  logic s,
  input  logic s1,
  input  logic s2,
  output logic y
);
  logic lo, hi;

  always_comb begin
    lo = 1'b0;
    hi = 1'b0;
    unique case ({s1, s2})
      2'd0: begin lo = a; hi = e; end
      2'd1: begin lo = b; hi = f; end
      2'd2: begin lo = c; hi = g; end
      default: begin lo = d; hi = h; end
    endcase
  end

  assign y = s ? hi : lo;
endmodule

// File: rtl/piso8_mux_ctrl_idx.sv
// 3-bit up/down scan index counter with synchronous load and count enable.
module scan_idx_ctr
  import piso8_mux_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [IDX_W-1:0] ld_val,
  input  logic             en,
  input  logic             up,
  output logic [IDX_W-1:0] idx
);
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (ld)      idx_d = ld_val;
    else if (en) idx_d = up ? idx_q + 3'd1 : idx_q - 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idx_q <= '0;
    else     idx_q <= idx_d;
  end

  assign idx = idx_q;
endmodule

// File: rtl/piso8_mux_ctrl.sv
// Captures a parallel byte onto mux inputs a..h, walks the mux selects and registers y as a
// valid/ready serial stream, pulsing frame_done when the eighth bit is taken.
module piso8_mux_ctrl
  import piso8_mux_ctrl_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [NUM_IN-1:0] din,
  output logic              load_ready,
  output logic              a,
  output logic              b,
  output logic              c,
  output logic              d,
  output logic              e,
  output logic              f,
  output logic              g,
  output logic              h,
  output logic              s,
  output logic              s1,
  output logic              s2,
  input  logic              y,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              ser_last,
  input  logic              out_ready,
  output logic              frame_done,
  output logic              busy
);
  localparam logic [IDX_W-1:0] FIRST = first_idx(MSB_FIRST);
  localparam logic [IDX_W-1:0] LAST  = last_idx(MSB_FIRST);

  state_t            state_q, state_d;
  logic [NUM_IN-1:0] data_q, data_d;
  logic              ser_out_q, ser_out_d;
  logic              ser_valid_q, ser_valid_d;
  logic              ser_last_q, ser_last_d;
  logic              frame_done_q, frame_done_d;
  logic              load_ready_q, load_ready_d;
  logic              idx_ld, idx_en;
  logic [IDX_W-1:0]  idx;

  scan_idx_ctr u_idx (
    .clk    (clk),
    .rst    (rst),
    .ld     (idx_ld),
    .ld_val (FIRST),
    .en     (idx_en),
    .up     (~MSB_FIRST),
    .idx    (idx)
  );

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    ser_out_d    = ser_out_q;
    ser_valid_d  = ser_valid_q;
    ser_last_d   = ser_last_q;
    frame_done_d = 1'b0;
    idx_ld       = 1'b0;
    idx_en       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (load_valid && load_ready_q) begin
          data_d  = din;
          idx_ld  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // y reflects the select registered last cycle, so each step samples the current index.
        if (!ser_valid_q || out_ready) begin
          ser_out_d   = y;
          ser_valid_d = 1'b1;
          ser_last_d  = (idx == LAST);
          if (idx == LAST) state_d = ST_DRAIN;
          else             idx_en  = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (ser_valid_q && out_ready) begin
          ser_valid_d = 1'b0;
          if (ser_last_q) begin
            ser_last_d   = 1'b0;
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Ready only after a full cycle in IDLE, which keeps the frame_done cycle closed to loads.
    load_ready_d = (state_q == ST_IDLE) && (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      data_q       <= '0;
      ser_out_q    <= 1'b0;
      ser_valid_q  <= 1'b0;
      ser_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      load_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      ser_out_q    <= ser_out_d;
      ser_valid_q  <= ser_valid_d;
      ser_last_q   <= ser_last_d;
      frame_done_q <= frame_done_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign {h, g, f, e, d, c, b, a} = data_q;
  assign {s, s1, s2} = idx;
  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign ser_last    = ser_last_q;
  assign frame_done  = frame_done_q;
  assign load_ready  = load_ready_q;
  assign busy        = (state_q != ST_IDLE);
endmodule
